// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helper for the vector data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic {CPU_PRIO, HOST_FORCE} arb_state_t;

   typedef enum logic [1:0] {SRC_NONE, SRC_CPU, SRC_HOST} arb_src_t;

   // Starvation counter must hold 0..limit inclusive.
   function automatic int unsigned STARVE_CNT_W(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Host grant and CPU stall event counters, wrapping modulo 2^STAT_WIDTH.
module mem_arb_stats #(
   parameter int unsigned STAT_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  host_grant,
   input  logic                  cpu_stall,
   output logic [STAT_WIDTH-1:0] host_grant_cnt,
   output logic [STAT_WIDTH-1:0] cpu_stall_cnt
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         host_grant_cnt <= '0;
         cpu_stall_cnt  <= '0;
      end else begin
         if (host_grant) host_grant_cnt <= host_grant_cnt + STAT_WIDTH'(1);
         if (cpu_stall)  cpu_stall_cnt  <= cpu_stall_cnt + STAT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port vector data memory between the CPU M stage and a host port.
// Optional statistics counters are enabled with MEM_ARB_STATS_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned VECTOR_SIZE   = 6,
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned STARVE_LIMIT  = 8
`ifdef MEM_ARB_STATS_EN
   ,
   parameter int unsigned STAT_WIDTH    = 16
`endif
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                cpuReq,
   input  logic                                cpuWrite,
   input  logic [ADDRESS_WIDTH-1:0]            cpuAddr,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   cpuWData,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   cpuRData,
   output logic                                cpuStall,
   input  logic                                hostValid,
   output logic                                hostReady,
   input  logic                                hostWrite,
   input  logic [ADDRESS_WIDTH-1:0]            hostAddr,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   hostWData,
   output logic                                hostRValid,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   hostRData,
   output logic                                memWE,
   output logic [ADDRESS_WIDTH-1:0]            memAddr,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   memWData,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   memRData
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]               hostGrantCnt,
   output logic [STAT_WIDTH-1:0]               cpuStallCnt
`endif
);

   localparam int unsigned CW = STARVE_CNT_W(STARVE_LIMIT);

   arb_state_t    state;
   arb_src_t      src;
   logic [CW-1:0] starve_cnt;
   logic          contend;
   logic          host_rd_acc;

   // Grant selection: CPU wins in CPU_PRIO, host wins in the forced slot.
   always_comb begin
      src      = SRC_NONE;
      cpuStall = 1'b0;
      case (state)
         CPU_PRIO: begin
            if (cpuReq)         src = SRC_CPU;
            else if (hostValid) src = SRC_HOST;
         end
         HOST_FORCE: begin
            if (hostValid) begin
               src      = SRC_HOST;
               cpuStall = cpuReq;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      memWE    = 1'b0;
      memAddr  = cpuAddr;
      memWData = cpuWData;
      case (src)
         SRC_CPU: memWE = cpuWrite;
         SRC_HOST: begin
            memWE    = hostWrite;
            memAddr  = hostAddr;
            memWData = hostWData;
         end
         default: ;
      endcase
   end

   assign hostReady   = (src == SRC_HOST);
   assign cpuRData    = memRData;
   assign contend     = (state == CPU_PRIO) && hostValid && cpuReq;
   assign host_rd_acc = hostReady && !hostWrite;

   // FSM, starvation counter and one-cycle host read response.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= CPU_PRIO;
         starve_cnt <= '0;
         hostRValid <= 1'b0;
         hostRData  <= '0;
      end else begin
         hostRValid <= host_rd_acc;
         if (host_rd_acc) hostRData <= memRData;
         case (state)
            CPU_PRIO: begin
               if (hostReady || !hostValid)
                  starve_cnt <= '0;
               else if (contend && starve_cnt != CW'(STARVE_LIMIT))
                  starve_cnt <= starve_cnt + CW'(1);
               if (contend && starve_cnt == CW'(STARVE_LIMIT - 1))
                  state <= HOST_FORCE;
            end
            HOST_FORCE: begin
               state      <= CPU_PRIO;
               starve_cnt <= '0;
            end
            default: state <= CPU_PRIO;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   mem_arb_stats #(
      .STAT_WIDTH (STAT_WIDTH)
   ) u_stats (
      .clock          (clock),
      .reset          (reset),
      .host_grant     (hostReady),
      .cpu_stall      (cpuStall),
      .host_grant_cnt (hostGrantCnt),
      .cpu_stall_cnt  (cpuStallCnt)
   );
`else
   // Arbitration only; no statistics state.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory and a host read scoreboard.
module tb_mem_port_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned VS = 6;
   localparam int unsigned AW = 16;
   localparam int unsigned W  = DW * VS;
   localparam logic [W-1:0] A5_WORD = {12{8'hA5}};
   localparam logic [W-1:0] D4_WORD = {VS{16'h1234}};
   localparam logic [W-1:0] D5_WORD = {VS{16'h5A5A}};

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cpuReq, cpuWrite, cpuStall;
   logic [AW-1:0] cpuAddr;
   logic [W-1:0]  cpuWData, cpuRData;
   logic          hostValid, hostReady, hostWrite, hostRValid;
   logic [AW-1:0] hostAddr;
   logic [W-1:0]  hostWData, hostRData;
   logic          memWE;
   logic [AW-1:0] memAddr;
   logic [W-1:0]  memWData, memRData;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]   hostGrantCnt, cpuStallCnt;
`endif

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .DATA_WIDTH    (DW),
      .VECTOR_SIZE   (VS),
      .ADDRESS_WIDTH (AW),
      .STARVE_LIMIT  (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cpuReq     (cpuReq),
      .cpuWrite   (cpuWrite),
      .cpuAddr    (cpuAddr),
      .cpuWData   (cpuWData),
      .cpuRData   (cpuRData),
      .cpuStall   (cpuStall),
      .hostValid  (hostValid),
      .hostReady  (hostReady),
      .hostWrite  (hostWrite),
      .hostAddr   (hostAddr),
      .hostWData  (hostWData),
      .hostRValid (hostRValid),
      .hostRData  (hostRData),
      .memWE      (memWE),
      .memAddr    (memAddr),
      .memWData   (memWData),
      .memRData   (memRData)
`ifdef MEM_ARB_STATS_EN
      ,
      .hostGrantCnt (hostGrantCnt),
      .cpuStallCnt  (cpuStallCnt)
`endif
   );

   // Behavioural single-port memory: combinational read, clocked write.
   logic [W-1:0] mem [0:255];
   always @(posedge clock) if (memWE) mem[memAddr[7:0]] <= memWData;
   assign memRData = mem[memAddr[7:0]];

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   // Scoreboard: every host read response must match the oldest expected word.
   always @(negedge clock) begin
      if (!reset && hostRValid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rvalid_unexpected: got data %h with no read outstanding", hostRData);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (hostRData !== e) begin
               bad++;
               $display("FAIL rdata: got %h expected %h", hostRData, e);
            end
         end
      end
   end

   task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [W-1:0] cd, input logic hv, input logic hw,
                         input logic [AW-1:0] ha, input logic [W-1:0] hd);
      cpuReq = cr; cpuWrite = cw; cpuAddr = ca; cpuWData = cd;
      hostValid = hv; hostWrite = hw; hostAddr = ha; hostWData = hd;
   endtask

   task automatic set_idle();
      set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [W-1:0] bb_word(input int i);
      logic [DW-1:0] e;
      e = 16'hB000 + DW'(i);
      return {VS{e}};
   endfunction

   task automatic test_reset();
      set_in(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
      reset = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
         @(negedge clock);
         total++; if (hostReady !== 1'b0)  begin bad++; $display("FAIL reset_ready ph%0d: got %b expected 0", ph, hostReady); end
         total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL reset_rvalid ph%0d: got %b expected 0", ph, hostRValid); end
         total++; if (cpuStall !== 1'b0)   begin bad++; $display("FAIL reset_stall ph%0d: got %b expected 0", ph, cpuStall); end
         total++; if (memWE !== 1'b0)      begin bad++; $display("FAIL reset_we ph%0d: got %b expected 0", ph, memWE); end
         tick();
         reset = 1'b0;
      end
      set_idle();
      tick();
   endtask

   task automatic test_idle_host_read();
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0010, A5_WORD);
      @(negedge clock);
      total++; if (hostReady !== 1'b1) begin bad++; $display("FAIL preload_ready: got %b expected 1", hostReady); end
      total++; if (memWE !== 1'b1)     begin bad++; $display("FAIL preload_we: got %b expected 1", memWE); end
      total++; if (memAddr !== 16'h0010) begin bad++; $display("FAIL preload_addr: got %h expected 0010", memAddr); end
      tick();
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
      @(negedge clock);
      total++; if (hostReady !== 1'b1)  begin bad++; $display("FAIL read_ready: got %b expected 1", hostReady); end
      total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL write_noresp: got %b expected 0", hostRValid); end
      exp_q.push_back(A5_WORD);
      tick();
      set_idle();
      @(negedge clock);
      total++; if (hostRValid !== 1'b1) begin bad++; $display("FAIL read_rvalid: got %b expected 1", hostRValid); end
      tick();
      @(negedge clock);
      total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL read_pulse: got %b expected 0", hostRValid); end
   endtask

   task automatic test_cpu_priority();
      set_in(1'b1, 1'b1, 16'h0004, D4_WORD, 1'b1, 1'b0, 16'h0010, '0);
      @(negedge clock);
      total++; if (memWE !== 1'b1)       begin bad++; $display("FAIL prio_we: got %b expected 1", memWE); end
      total++; if (memAddr !== 16'h0004) begin bad++; $display("FAIL prio_addr: got %h expected 0004", memAddr); end
      total++; if (memWData !== D4_WORD) begin bad++; $display("FAIL prio_wdata: got %h expected %h", memWData, D4_WORD); end
      total++; if (hostReady !== 1'b0)   begin bad++; $display("FAIL prio_ready: got %b expected 0", hostReady); end
      total++; if (cpuStall !== 1'b0)    begin bad++; $display("FAIL prio_stall: got %b expected 0", cpuStall); end
      tick();
      set_in(1'b1, 1'b0, 16'h0004, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      total++; if (cpuRData !== D4_WORD) begin bad++; $display("FAIL prio_readback: got %h expected %h", cpuRData, D4_WORD); end
      tick();
      set_idle();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), bb_word(i));
         @(negedge clock);
         total++; if (hostReady !== 1'b1)  begin bad++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, hostReady); end
         total++; if (memAddr !== AW'(i))  begin bad++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, memAddr, AW'(i)); end
         total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL b2b_rvalid[%0d]: got %b expected 0", i, hostRValid); end
         tick();
      end
      set_idle();
      @(negedge clock);
      total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL b2b_rvalid_end: got %b expected 0", hostRValid); end
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
         @(negedge clock);
         total++; if (cpuRData !== bb_word(i)) begin bad++; $display("FAIL b2b_cpu_read[%0d]: got %h expected %h", i, cpuRData, bb_word(i)); end
         tick();
      end
      set_idle();
      tick();
   endtask

   task automatic test_starvation();
      logic eh;
      do_reset();
      set_in(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
      for (int k = 1; k <= 27; k++) begin
         eh = (k % 9 == 0);
         @(negedge clock);
         total++; if (hostReady !== eh) begin bad++; $display("FAIL starve_ready c%0d: got %b expected %b", k, hostReady, eh); end
         total++; if (cpuStall !== eh)  begin bad++; $display("FAIL starve_stall c%0d: got %b expected %b", k, cpuStall, eh); end
         total++; if (memAddr !== (eh ? 16'h0010 : 16'h0004)) begin bad++; $display("FAIL starve_addr c%0d: got %h expected %h", k, memAddr, eh ? 16'h0010 : 16'h0004); end
         if (eh) exp_q.push_back(A5_WORD);
         tick();
      end
      set_idle();
`ifdef MEM_ARB_STATS_EN
      total++; if (hostGrantCnt !== 16'd3) begin bad++; $display("FAIL stats_grant: got %0d expected 3", hostGrantCnt); end
      total++; if (cpuStallCnt !== 16'd3)  begin bad++; $display("FAIL stats_stall: got %0d expected 3", cpuStallCnt); end
`endif
      tick();
      tick();
   endtask

   task automatic test_force_boundaries();
      // Forced slot with the CPU idle: host served, no stall.
      do_reset();
      set_in(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
      for (int k = 0; k < 8; k++) tick();
      set_in(1'b0, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
      @(negedge clock);
      total++; if (hostReady !== 1'b1) begin bad++; $display("FAIL force_nocpu_ready: got %b expected 1", hostReady); end
      total++; if (cpuStall !== 1'b0)  begin bad++; $display("FAIL force_nocpu_stall: got %b expected 0", cpuStall); end
      exp_q.push_back(A5_WORD);
      tick();
      set_idle();
      tick();
      // Forced slot with host withdrawn: nobody granted, then CPU resumes.
      do_reset();
      set_in(1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0010, '0);
      for (int k = 0; k < 8; k++) tick();
      set_in(1'b1, 1'b1, 16'h0005, D5_WORD, 1'b0, 1'b0, 16'h0010, '0);
      @(negedge clock);
      total++; if (hostReady !== 1'b0)   begin bad++; $display("FAIL force_nohost_ready: got %b expected 0", hostReady); end
      total++; if (cpuStall !== 1'b0)    begin bad++; $display("FAIL force_nohost_stall: got %b expected 0", cpuStall); end
      total++; if (memWE !== 1'b0)       begin bad++; $display("FAIL force_nohost_we: got %b expected 0", memWE); end
      total++; if (memAddr !== 16'h0005) begin bad++; $display("FAIL force_nohost_addr: got %h expected 0005", memAddr); end
      tick();
      @(negedge clock);
      total++; if (memWE !== 1'b1)    begin bad++; $display("FAIL force_resume_we: got %b expected 1", memWE); end
      total++; if (cpuStall !== 1'b0) begin bad++; $display("FAIL force_resume_stall: got %b expected 0", cpuStall); end
      tick();
      set_idle();
      tick();
   endtask

   task automatic test_reset_mid();
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
      @(negedge clock);
      total++; if (hostReady !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b expected 1", hostReady); end
      reset = 1'b1;
      set_idle();
      tick();
      @(negedge clock);
      total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_in_reset: got %b expected 0", hostRValid); end
      reset = 1'b0;
      tick();
      @(negedge clock);
      total++; if (hostRValid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_after: got %b expected 0", hostRValid); end
      tick();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_idle_host_read();
      test_cpu_priority();
      test_back_to_back();
      test_starvation();
      test_force_boundaries();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d reads outstanding expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
